seg_scan_display: RTL

Multiplexed hex seven-segment display driver, the consumer of the 1 kHz scan and 1 Hz control timebases produced by the system clock divider. It runs on the board clock and accepts those timebases as one-cycle enable strobes, not as derived clocks. It scans one digit per scan strobe and decodes hex nibbles to active-low segments. It supports leading-zero blanking and per-digit blinking, and commits new display values only at frame boundaries so a value never tears mid-frame.

---
 rtl/seg_scan_display.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/seg_scan_display.sv
// rtl/seg_scan_display.sv - multiplexed hex seven-segment scan driver with frame-synchronous value commit
module seg_scan_display #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scan_tick,
    input  logic                  blink_tick,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blink_en,
    input  logic                  blank_lz,
    input  logic                  load,
    output logic                  load_ack,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    // Shadow copy written by load; committed copy drives the scan.
    logic [4*DIGITS-1:0] shadow_val;
    logic [DIGITS-1:0]   shadow_dp;
    logic                pending;
    logic [4*DIGITS-1:0] disp_val;
    logic [DIGITS-1:0]   disp_dp;
    logic [IW-1:0]       idx;
    logic                phase;

    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_blink;
    logic                upper_zero;
    logic                lz_blank;
    logic [DIGITS-1:0]   an_next;
    logic [6:0]          seg_next;
    logic                dp_next;
    logic                frame_end;
    logic                commit;

    // Active-low gfedcba pattern for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0:    hex_to_seg = 7'h40;
            4'h1:    hex_to_seg = 7'h79;
            4'h2:    hex_to_seg = 7'h24;
            4'h3:    hex_to_seg = 7'h30;
            4'h4:    hex_to_seg = 7'h19;
            4'h5:    hex_to_seg = 7'h12;
            4'h6:    hex_to_seg = 7'h02;
            4'h7:    hex_to_seg = 7'h78;
            4'h8:    hex_to_seg = 7'h00;
            4'h9:    hex_to_seg = 7'h10;
            4'hA:    hex_to_seg = 7'h08;
            4'hB:    hex_to_seg = 7'h03;
            4'hC:    hex_to_seg = 7'h46;
            4'hD:    hex_to_seg = 7'h21;
            4'hE:    hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

    // Select the current digit's data and build the next output pattern.
    always_comb begin
        cur_nib    = 4'h0;
        cur_dp     = 1'b0;
        cur_blink  = 1'b0;
        upper_zero = 1'b1;
        an_next    = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IW'(k)) begin
                cur_nib    = disp_val[4*k +: 4];
                cur_dp     = disp_dp[k];
                cur_blink  = blink_en[k];
                an_next[k] = 1'b0;
            end
            if ((IW'(k) >= idx) && (disp_val[4*k +: 4] != 4'h0)) begin
                upper_zero = 1'b0;
            end
        end
        // Digit 0 always shows, so a zero value still reads "0".
        lz_blank = blank_lz && (idx != '0) && upper_zero;
        if (phase && cur_blink) begin
            seg_next = 7'h7F;
            dp_next  = 1'b1;
        end else if (lz_blank) begin
            seg_next = 7'h7F;
            dp_next  = ~cur_dp;
        end else begin
            seg_next = hex_to_seg(cur_nib);
            dp_next  = ~cur_dp;
        end
        frame_end = scan_tick && (idx == LAST_IDX);
        commit    = frame_end && (pending || load);
    end

    // Scan position and registered digit outputs; they move only on scan_tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx <= '0;
            an  <= '1;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else if (scan_tick) begin
            an  <= an_next;
            seg <= seg_next;
            dp  <= dp_next;
            idx <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
        end
    end

    // Blink phase; the scan path above samples it before this toggle lands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase <= 1'b0;
        end else if (blink_tick) begin
            phase <= ~phase;
        end
    end

    // Load capture and commit at the frame boundary, with the one-cycle ack.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_val <= '0;
            shadow_dp  <= '0;
            pending    <= 1'b0;
            disp_val   <= '0;
            disp_dp    <= '0;
            load_ack   <= 1'b0;
        end else begin
            load_ack <= 1'b0;
            if (load) begin
                shadow_val <= value;
                shadow_dp  <= dp_in;
            end
            if (commit) begin
                // A load landing on the boundary bypasses the shadow.
                disp_val <= load ? value : shadow_val;
                disp_dp  <= load ? dp_in : shadow_dp;
                pending  <= 1'b0;
                load_ack <= 1'b1;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

endmodule
